// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types, extended with the branch target buffer constants
// and the branch-resolution bundle carried down the pipeline registers.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Weakly not-taken: MSB clear, every lower bit set (0 for a 1-bit counter).
  function automatic logic [31:0] btb_weak_nt(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Weakly taken: MSB set, every lower bit clear.
  function automatic logic [31:0] btb_weak_t(input int w);
    return 32'd1 << (w - 1);
  endfunction

  typedef struct packed {
    logic  valid;
    word_t pc;
    logic  taken;
    word_t target;
    logic  mispredict;
  } btb_upd_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Datapath <-> branch predictor connection: IF lookup, EX/MEM update, statistics.
interface branch_predictor_if
  import cpu_types_pkg::*;
#(
  parameter int STAT_W = 32
);
  word_t              lk_pc;
  logic               lk_hit;
  logic               lk_taken;
  word_t              lk_target;
  logic               upd_valid;
  word_t              upd_pc;
  logic               upd_taken;
  word_t              upd_target;
  logic               upd_mispredict;
  logic               inval;
  logic               stat_clr;
  logic [STAT_W-1:0]  stat_branches;
  logic [STAT_W-1:0]  stat_mispredicts;

  modport bp (
    input  lk_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
           inval, stat_clr,
    output lk_hit, lk_taken, lk_target, stat_branches, stat_mispredicts
  );

  modport dp (
    output lk_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
           inval, stat_clr,
    input  lk_hit, lk_taken, lk_target, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/sat_counter.sv
// Next-value logic for a W-bit saturating up/down counter; holds at 0 and all-ones.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] i_cnt,
  input  logic         i_en,
  input  logic         i_up,
  output logic [W-1:0] o_next
);
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] MIN = '0;

  always_comb begin
    o_next = i_cnt;
    if (i_en) begin
      if (i_up) begin
        if (i_cnt != MAX) o_next = i_cnt + ONE;
        else              o_next = i_cnt;
      end else begin
        if (i_cnt != MIN) o_next = i_cnt - ONE;
        else              o_next = i_cnt;
      end
    end else begin
      o_next = i_cnt;
    end
  end
endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with saturating direction counters: combinational IF lookup,
// synchronous update from branch resolution, saturating misprediction statistics.
module branch_target_predictor
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  word_t             lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output word_t             lk_target,
  input  logic              upd_valid,
  input  word_t             upd_pc,
  input  logic              upd_taken,
  input  word_t             upd_target,
  input  logic              upd_mispredict,
  input  logic              inval,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;
  localparam logic [CNT_W-1:0]  WEAK_NT  = CNT_W'(btb_weak_nt(CNT_W));
  localparam logic [CNT_W-1:0]  WEAK_T   = CNT_W'(btb_weak_t(CNT_W));
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  word_t              r_target [ENTRIES];
  logic [CNT_W-1:0]   r_cnt    [ENTRIES];
  logic [STAT_W-1:0]  r_branches;
  logic [STAT_W-1:0]  r_mispredicts;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic [CNT_W-1:0] w_cnt_next;
  word_t            w_seq_pc;
  logic             w_unused_pc_lsbs;

  // Word-aligned PCs: the two low bits never take part in index or tag.
  assign w_unused_pc_lsbs = ^{lk_pc[1:0], upd_pc[1:0]};

  assign w_lk_idx  = lk_pc[IDX_W+1:2];
  assign w_lk_tag  = lk_pc[31:IDX_W+2];
  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = upd_pc[31:IDX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Lookup reads pre-edge state only; an update to the same entry is not bypassed.
  assign lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign lk_taken  = lk_hit && r_cnt[w_lk_idx][CNT_W-1];
  assign w_seq_pc  = lk_pc + 32'd4;
  assign lk_target = lk_taken ? r_target[w_lk_idx] : w_seq_pc;

  assign stat_branches    = r_branches;
  assign stat_mispredicts = r_mispredicts;

  sat_counter #(.W(CNT_W)) u_sat_counter (
    .i_cnt  (r_cnt[w_upd_idx]),
    .i_en   (w_upd_hit),
    .i_up   (upd_taken),
    .o_next (w_cnt_next)
  );

  // BTB entry storage: invalidate-all beats update; only taken misses allocate.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= 32'd0;
        r_cnt[i]    <= WEAK_NT;
      end
    end else if (inval) begin
      r_valid <= '0;
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        r_cnt[w_upd_idx] <= w_cnt_next;
        if (upd_taken) r_target[w_upd_idx] <= upd_target;
      end else if (upd_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target;
        r_cnt[w_upd_idx]    <= WEAK_T;
      end
    end
  end

  // Saturating statistics; clear has priority over a same-cycle increment.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_branches    <= '0;
      r_mispredicts <= '0;
    end else if (stat_clr) begin
      r_branches    <= '0;
      r_mispredicts <= '0;
    end else if (upd_valid) begin
      if (r_branches != STAT_MAX) r_branches <= r_branches + STAT_ONE;
      if (upd_mispredict && (r_mispredicts != STAT_MAX))
        r_mispredicts <= r_mispredicts + STAT_ONE;
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed self-checking bench for branch_target_predictor (ENTRIES=16, CNT_W=2, STAT_W=4).
module tb_branch_target_predictor;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  word_t       lk_pc;
  logic        lk_hit;
  logic        lk_taken;
  word_t       lk_target;
  logic        upd_valid;
  word_t       upd_pc;
  logic        upd_taken;
  word_t       upd_target;
  logic        upd_mispredict;
  logic        inval;
  logic        stat_clr;
  logic [3:0]  stat_branches;
  logic [3:0]  stat_mispredicts;

  int checks_s;
  int errors_s;

  branch_target_predictor #(.ENTRIES(16), .CNT_W(2), .STAT_W(4)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .lk_pc            (lk_pc),
    .lk_hit           (lk_hit),
    .lk_taken         (lk_taken),
    .lk_target        (lk_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .inval            (inval),
    .stat_clr         (stat_clr),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_s++;
    if (got !== exp) begin
      errors_s++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Lookup at pc, let combinational outputs settle, compare hit/taken/target.
  task automatic look(input string tag, input word_t pc, input logic hit,
                      input logic tkn, input word_t tgt);
    lk_pc = pc;
    #1;
    check_eq({tag, "_hit"},    32'(lk_hit),   32'(hit));
    check_eq({tag, "_taken"},  32'(lk_taken), 32'(tkn));
    check_eq({tag, "_target"}, lk_target,     tgt);
  endtask

  // One-cycle update pulse; inputs change 1 time unit after the active edge.
  task automatic upd(input word_t pc, input logic tkn, input word_t tgt, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tkn; upd_target = tgt; upd_mispredict = mis;
    @(posedge CLK); #1;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  initial begin
    checks_s = 0; errors_s = 0;
    nRST = 1'b0; lk_pc = 32'h40; upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0;
    upd_target = 32'd0; upd_mispredict = 1'b0; inval = 1'b0; stat_clr = 1'b0;
    #12;
    look("rst", 32'h40, 1'b0, 1'b0, 32'h44);
    check_eq("rst_br",  32'(stat_branches),    32'd0);
    check_eq("rst_mis", 32'(stat_mispredicts), 32'd0);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Allocate 0x40 taken -> cnt=2 (weak taken)
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
    check_eq("alloc_br", 32'(stat_branches), 32'd1);

    // cnt 2->1->0
    upd(32'h40, 1'b0, 32'h999, 1'b0);
    look("nt1", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h999, 1'b0);
    for (int i = 0; i < 3; i++) upd(32'h40, 1'b0, 32'h999, 1'b0);
    // held at 0: a single taken update lands on 1, still not taken
    upd(32'h40, 1'b1, 32'h104, 1'b0);
    look("sat0", 32'h40, 1'b1, 1'b0, 32'h44);
    for (int i = 0; i < 3; i++) upd(32'h40, 1'b1, 32'h108, 1'b0);
    look("sat3", 32'h40, 1'b1, 1'b1, 32'h108);
    // from 3: down to 2 (taken), then 1 (not taken)
    upd(32'h40, 1'b0, 32'h999, 1'b0);
    look("dn2", 32'h40, 1'b1, 1'b1, 32'h108);
    upd(32'h40, 1'b0, 32'h999, 1'b0);
    look("dn1", 32'h40, 1'b1, 1'b0, 32'h44);
    check_eq("br12", 32'(stat_branches), 32'd12);

    // stat_clr beats a same-cycle mispredict update
    stat_clr = 1'b1;
    upd(32'h40, 1'b0, 32'h999, 1'b1);
    stat_clr = 1'b0;
    check_eq("clr_br",  32'(stat_branches),    32'd0);
    check_eq("clr_mis", 32'(stat_mispredicts), 32'd0);

    // Alias: 0x80 shares index 0 with 0x40
    upd(32'h80, 1'b1, 32'h200, 1'b0);
    look("alias40", 32'h40, 1'b0, 1'b0, 32'h44);
    look("alias80", 32'h80, 1'b1, 1'b1, 32'h200);

    // Not-taken miss never allocates
    upd(32'hC4, 1'b0, 32'h300, 1'b0);
    look("ntmiss", 32'hC4, 1'b0, 1'b0, 32'hC8);

    // Same-cycle lookup and update: pre-edge contents
    lk_pc = 32'h80;
    upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1; upd_target = 32'h300;
    #1;
    check_eq("nobyp_target", lk_target, 32'h200);
    @(posedge CLK); #1;
    upd_valid = 1'b0;
    look("postupd", 32'h80, 1'b1, 1'b1, 32'h300);
    check_eq("br3", 32'(stat_branches), 32'd3);

    // inval overrides same-cycle allocate; stats still count
    inval = 1'b1;
    upd(32'h140, 1'b1, 32'h400, 1'b1);
    inval = 1'b0;
    look("inv80",  32'h80,  1'b0, 1'b0, 32'h84);
    look("inv140", 32'h140, 1'b0, 1'b0, 32'h144);
    check_eq("inv_br",  32'(stat_branches),    32'd4);
    check_eq("inv_mis", 32'(stat_mispredicts), 32'd1);

    // Mispredict saturation at 15 with 4-bit stats
    stat_clr = 1'b1;
    @(posedge CLK); #1;
    stat_clr = 1'b0;
    for (int i = 0; i < 14; i++) upd(32'h10, 1'b0, 32'h0, 1'b1);
    check_eq("mis14", 32'(stat_mispredicts), 32'd14);
    for (int i = 0; i < 2; i++) upd(32'h10, 1'b0, 32'h0, 1'b1);
    check_eq("mis_sat", 32'(stat_mispredicts), 32'd15);
    check_eq("br_sat",  32'(stat_branches),    32'd15);

    // Reset mid-update, between clock edges
    upd(32'h80, 1'b1, 32'h500, 1'b0);
    look("pre_rst", 32'h80, 1'b1, 1'b1, 32'h500);
    upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1; upd_target = 32'h600;
    #2;
    nRST = 1'b0;
    look("mid_rst", 32'h80, 1'b0, 1'b0, 32'h84);
    check_eq("mid_rst_br",  32'(stat_branches),    32'd0);
    check_eq("mid_rst_mis", 32'(stat_mispredicts), 32'd0);
    upd_valid = 1'b0;
    @(posedge CLK); #2;
    nRST = 1'b1;
    @(posedge CLK); #1;
    look("post_rst", 32'h80, 1'b0, 1'b0, 32'h84);

    $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
    $finish;
  end
endmodule
